fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the write port of one syn_fifo among N requesters.

---
 rtl/fifo_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among N requesters,
// granting bursts of up to MAX_BURST words and stalling on fifo_full.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*DW-1:0]      data_in,
    output logic [N-1:0]         ack,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [DW-1:0]        fifo_din,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IW-1:0] last_gnt_q, last_gnt_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;

    logic [DW-1:0] req_data [N];
    logic [IW-1:0] cand;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          owner_req;
    logic          wr_en;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_data[i] = data_in[i*DW +: DW];
        end
    end

    // Rotating search starting one past the last grant, so nobody starves.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(last_gnt_q) + 1 + k) % N);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_req = req[gnt_idx_q];
        wr_en     = (state_q == ST_GRANT) && owner_req && !fifo_full;
        fifo_wr   = wr_en;
        fifo_din  = '0;
        ack       = '0;
        if (state_q == ST_GRANT) begin
            fifo_din = req_data[gnt_idx_q];
        end
        if (wr_en) begin
            ack[gnt_idx_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d     = ST_GRANT;
                    gnt_idx_d   = pick_idx;
                    last_gnt_d  = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                // A dropped request ends the grant; a full FIFO just holds it.
                if (!owner_req) begin
                    state_d = ST_IDLE;
                end else if (wr_en) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (burst_cnt_q == BURST_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_idx_q   <= '0;
            last_gnt_q  <= LAST_IDX;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign gnt_idx = gnt_idx_q;
    assign busy    = (state_q == ST_GRANT);

    a_no_wr_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_wr && fifo_full));
    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(ack));
    a_burst_bound: assert property (@(posedge clk) disable iff (!rst_n)
        burst_cnt_q <= BURST_MAX);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: models four producers and a 16-deep FIFO,
// and checks grant order, burst lengths, backpressure, early drop and reset.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  ack;
    logic        fifo_full = 1'b0;
    logic        fifo_wr;
    logic [7:0]  fifo_din;
    logic [1:0]  gnt_idx;
    logic        busy;

    int          want [4];
    int          sent [4];
    int          baseV [4];
    int          stepV [4];
    int          ackCnt [4];
    int          wrTotal;
    int          nCmp = 0;
    int          nErr = 0;

    logic        pendWr = 1'b0;
    logic [7:0]  pendDin = '0;
    logic [3:0]  pendAck = '0;
    logic        prevBusy = 1'b0;
    logic [31:0] wrHist = '0;
    bit          limitEn = 1'b0;
    bit          forceFull = 1'b0;

    logic        sWr, sBusy;
    logic [3:0]  sAck;
    logic [1:0]  sGnt;

    logic [7:0]  fifoQ [$];
    logic [7:0]  expQ [$];
    int          grantLog [$];
    int          expG [$];

    fifo_wr_arbiter #(.N(4), .DW(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .gnt_idx   (gnt_idx),
        .busy      (busy)
    );

    // Free-running 10-time-unit clock; posedges land on 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: commit last cycle's write/acks, drive producers, sample outputs.
    task automatic applyStimulus();
        @(negedge clk);
        if (pendWr) fifoQ.push_back(pendDin);
        for (int i = 0; i < 4; i++) begin
            if (pendAck[i]) sent[i]++;
        end
        pendWr  = 1'b0;
        pendAck = '0;
        for (int i = 0; i < 4; i++) begin
            req[i] = (sent[i] < want[i]);
            data_in[i*8 +: 8] = 8'(baseV[i] + stepV[i] * sent[i]);
        end
        fifo_full = forceFull || (limitEn && fifoQ.size() >= 16);
        #1;
        sWr   = fifo_wr;
        sBusy = busy;
        sAck  = ack;
        sGnt  = gnt_idx;
        checkOutput("wr_while_full", {31'd0, fifo_wr & fifo_full}, 32'd0);
        if (fifo_wr) begin
            pendWr  = 1'b1;
            pendDin = fifo_din;
            wrTotal++;
        end
        pendAck = ack;
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) ackCnt[i]++;
        end
        if (busy && !prevBusy) grantLog.push_back(int'(gnt_idx));
        prevBusy = busy;
        wrHist   = {wrHist[30:0], fifo_wr};
    endtask

    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) applyStimulus();
    endtask

    task automatic clearState();
        for (int i = 0; i < 4; i++) begin
            want[i]   = 0;
            sent[i]   = 0;
            ackCnt[i] = 0;
            baseV[i]  = i * 64;
            stepV[i]  = 1;
        end
        wrTotal = 0;
        wrHist  = '0;
        grantLog.delete();
        fifoQ.delete();
        expQ.delete();
    endtask

    task automatic pushExp(input int base, input int step, input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) expQ.push_back(8'(base + step * k));
    endtask

    task automatic checkFifo(input string tag);
        checkOutput({tag, "_count"}, 32'(fifoQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s_word%0d", tag, i),
                        (i < fifoQ.size()) ? 32'(fifoQ[i]) : 32'hDEAD_BEEF, 32'(expQ[i]));
        end
        fifoQ.delete();
        expQ.delete();
    endtask

    task automatic checkGrants(input string tag);
        checkOutput({tag, "_grants"}, 32'(grantLog.size()), 32'(expG.size()));
        for (int i = 0; i < expG.size(); i++) begin
            checkOutput($sformatf("%s_grant%0d", tag, i),
                        (i < grantLog.size()) ? 32'(grantLog[i]) : 32'hDEAD_BEEF, 32'(expG[i]));
        end
    endtask

    // Directed test sequence, one scenario after another, then the summary.
    initial begin
        clearState();

        // Reset held with every requester active: nothing may happen.
        want[0] = 8; want[1] = 4; want[2] = 4; want[3] = 4;
        runCycles(2);
        checkOutput("rst_busy", {31'd0, sBusy}, 32'd0);
        checkOutput("rst_wr",   {31'd0, sWr},   32'd0);
        checkOutput("rst_ack",  {28'd0, sAck},  32'd0);
        checkOutput("rst_gnt",  {30'd0, sGnt},  32'd0);
        checkOutput("rst_din",  {24'd0, fifo_din}, 32'd0);
        rst_n = 1'b1;

        // All requesters: rotation 0,1,2,3 then back to 0 for its second burst.
        runCycles(26);
        expG = '{0, 1, 2, 3, 0};
        checkGrants("all");
        checkOutput("all_ack0", 32'(ackCnt[0]), 32'd8);
        checkOutput("all_ack1", 32'(ackCnt[1]), 32'd4);
        checkOutput("all_ack2", 32'(ackCnt[2]), 32'd4);
        checkOutput("all_ack3", 32'(ackCnt[3]), 32'd4);
        pushExp(0, 1, 0, 4); pushExp(64, 1, 0, 4); pushExp(128, 1, 0, 4);
        pushExp(192, 1, 0, 4); pushExp(0, 1, 4, 4);
        checkFifo("all");

        // Single requester 2 with 8 words: two bursts separated by one IDLE.
        clearState();
        want[2] = 8; baseV[2] = 8'h11; stepV[2] = 8'h11;
        runCycles(11);
        checkOutput("single_wr_pattern", {21'd0, wrHist[10:0]}, 32'b01111011110);
        expG = '{2, 2};
        checkGrants("single");
        pushExp(8'h11, 8'h11, 0, 8);
        checkFifo("single");

        // Backpressure: FIFO full for 3 cycles after 2 writes of requester 1.
        clearState();
        want[1] = 4;
        runCycles(3);
        forceFull = 1'b1;
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput($sformatf("bp_wr%0d", c),   {31'd0, sWr},   32'd0);
            checkOutput($sformatf("bp_ack%0d", c),  {28'd0, sAck},  32'd0);
            checkOutput($sformatf("bp_gnt%0d", c),  {30'd0, sGnt},  32'd1);
            checkOutput($sformatf("bp_busy%0d", c), {31'd0, sBusy}, 32'd1);
        end
        forceFull = 1'b0;
        runCycles(2);
        checkOutput("bp_busy_last", {31'd0, sBusy}, 32'd1);
        applyStimulus();
        checkOutput("bp_busy_end", {31'd0, sBusy}, 32'd0);
        checkOutput("bp_total", 32'(wrTotal), 32'd4);
        pushExp(64, 1, 0, 4);
        checkFifo("bp");

        // Early drop: requester 1 leaves after 2 words, pending requester 3 follows.
        clearState();
        want[1] = 2; baseV[1] = 8'h50;
        runCycles(1);
        want[3] = 4;
        runCycles(3);
        checkOutput("drop_wr",   {31'd0, sWr},   32'd0);
        checkOutput("drop_busy", {31'd0, sBusy}, 32'd1);
        applyStimulus();
        checkOutput("drop_idle", {31'd0, sBusy}, 32'd0);
        runCycles(5);
        expG = '{1, 3};
        checkGrants("drop");
        checkOutput("drop_ack1", 32'(ackCnt[1]), 32'd2);
        checkOutput("drop_ack3", 32'(ackCnt[3]), 32'd4);
        checkOutput("drop_total", 32'(wrTotal), 32'd6);
        pushExp(8'h50, 1, 0, 2); pushExp(192, 1, 0, 4);
        checkFifo("drop");

        // Fill the 16-deep FIFO, then free exactly one slot.
        clearState();
        limitEn = 1'b1;
        want[0] = 20;
        runCycles(25);
        checkOutput("fill_total", 32'(wrTotal), 32'd16);
        checkOutput("fill_wr",    {31'd0, sWr},   32'd0);
        checkOutput("fill_busy",  {31'd0, sBusy}, 32'd1);
        checkOutput("fill_head",  32'(fifoQ.pop_front()), 32'd0);
        runCycles(4);
        checkOutput("fill_one_more", 32'(wrTotal), 32'd17);
        limitEn = 1'b0;
        runCycles(5);
        checkOutput("fill_done_busy", {31'd0, sBusy}, 32'd0);
        pushExp(0, 1, 1, 19);
        checkFifo("fill");

        // Reset asserted while requester 2 is mid-burst with a write on the bus.
        clearState();
        want[2] = 4;
        runCycles(3);
        checkOutput("mid_wr_before", {31'd0, sWr}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_wr",   {31'd0, fifo_wr}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy},    32'd0);
        checkOutput("mid_rst_ack",  {28'd0, ack},     32'd0);
        checkOutput("mid_rst_din",  {24'd0, fifo_din}, 32'd0);
        checkOutput("mid_rst_gnt",  {30'd0, gnt_idx}, 32'd0);
        pendWr  = 1'b0;
        pendAck = '0;
        want[1] = 4; want[3] = 4;
        grantLog.delete();
        runCycles(2);
        rst_n = 1'b1;
        runCycles(17);
        expG = '{1, 2, 3};
        checkGrants("mid");
        pushExp(128, 1, 0, 1); pushExp(64, 1, 0, 4);
        pushExp(128, 1, 1, 3); pushExp(192, 1, 0, 4);
        checkFifo("mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
